vx_issue_scoreboard: RTL and testbench
======================================

Name: vx_issue_scoreboard

Overview:
- Sits directly downstream of the per-warp instruction buffers. Consumes one instruction stream per warp and tracks in-flight destination registers, scalar and vector, per warp.
- Blocks any warp whose head instruction has a RAW or WAW hazard.
- Round-robin arbitrates among hazard-free warps into a single registered issue port feeding operand collection.
- Releases reservations on writeback.

Parameters:
- PER_ISSUE_WARPS, 4, number of warps (instruction streams) served; wid width WW = max(1, clog2(PER_ISSUE_WARPS)).
- NR_BITS, 6, scalar register index width (64 scalar regs, index 0 hardwired zero).
- NV_BITS, 5, vector register index width (32 vector regs).
- PAYLOAD_W, 128, opaque instruction bits (uuid, tmask, PC, ex/op type, args) passed through untouched.
- PERF_W, 44, width of the stall counter.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- ibuf_valid  in  W  head-of-buffer valid, one bit per warp
- ibuf_ready  out  W  pop strobe per warp
- ibuf_payload  in  W*PAYLOAD_W  opaque fields
- ibuf_wb  in  W  instruction writes a destination
- ibuf_is_vec  in  W  destination and sources are vector registers
- ibuf_rd, ibuf_rs1, ibuf_rs2, ibuf_rs3  in  W*NR_BITS each  scalar indices
- ibuf_vd, ibuf_vs1, ibuf_vs2  in  W*NV_BITS each  vector indices
- out_valid  out  1  issued instruction valid
- out_ready  in  1  downstream accept
- out_wid  out  WW  issuing warp
- out_payload  out  PAYLOAD_W; out_is_vec out 1; out_rd/rs1/rs2/rs3 out NR_BITS; out_vd/vs1/vs2 out NV_BITS  registered copies
- wb_valid  in  1  writeback commit
- wb_wid  in  WW
- wb_is_vec  in  1
- wb_rd  in  NR_BITS  scalar index, used when wb_is_vec=0
- wb_vd  in  NV_BITS  vector index, used when wb_is_vec=1
- perf_stalls  out  PERF_W  hazard stall cycle count
- err_spurious_wb  out  1  sticky error flag

Behaviour:
- State: sbusy[W][64] and vbusy[W][32], registered bitmaps. Round-robin pointer rr[WW]. One-entry output register with valid flag.
- Reset clears bitmaps, rr, output valid, perf_stalls and err_spurious_wb. All outputs are 0 after reset.
- Hazard, computed from registered bitmaps of warp w:
  - Scalar instruction: sbusy[rs1|rs2|rs3], plus sbusy[rd] if wb.
  - Vector instruction: vbusy[vs1|vs2], plus vbusy[vd] if wb, plus sbusy[rs1] (scalar operand of vector-scalar ops).
  - Index 0 of sbusy reads as 0 and is never set.
- eligible[w] = ibuf_valid[w] & ~hazard[w].
- can_load = ~out_valid | out_ready.
- Grant: first eligible warp at or after rr, wrapping. Only when can_load and any eligible.
- On grant g in cycle n:
  - ibuf_ready[g]=1; all other ibuf_ready bits are 0.
  - Output register loads at edge n. out_valid=1 in cycle n+1, so issue latency is 1 cycle.
  - rr <= g+1 modulo PER_ISSUE_WARPS.
  - If wb: set sbusy[g][rd] (rd≠0) or vbusy[g][vd].
- Output holds stable while out_valid & ~out_ready. Back-to-back issue at 1 per cycle is allowed when out_ready=1.
- Writeback at cycle n clears the bit at edge n. Dependent instruction may be granted in cycle n+1. No same-cycle bypass.
- Simultaneous reserve and release of the same bit in the same cycle: reserve wins, bit stays 1.
- wb to a bit that is already 0: no state change; err_spurious_wb sets and stays set until reset.
- wb with wb_is_vec=0 and wb_rd=0: ignored, no error.
- perf_stalls increments by 1 each cycle where any ibuf_valid=1, no grant occurs, and can_load=1 (pure hazard stall). It saturates at all-ones.
- Reset mid-operation: in-flight reservations are lost. Upstream and downstream stages are reset together.

Decomposition:
- Shared package holds WW, the register-index widths, and a packed issue-record typedef (payload, is_vec, rd/rs*, vd/vs*) used by out_* and by the operand stage.
- One natural sub-module: vx_rr_arbiter (W requests, pointer, one-hot and encoded grant).

Test Plan:
- Independence: warp0 issues add x5←x1,x2 (wb=1), then x6←x3,x4. Required: both issue on consecutive cycles; sbusy[0][5] and [0][6] are set.
- RAW stall: warp0 issues x5←…, then x7←x5,x1. Required: second stalls and perf_stalls increments each cycle. wb_valid(wid0, rd5) at cycle 10 → grant at cycle 11, out_valid at cycle 12.
- Vector WAW plus scalar source: warp1 issues vd=3 (vec), then vec vd=3 with rs1=x9 while x9 is busy. Required: blocked until both v3 and x9 are released.
- Round-robin: all 4 warps hazard-free and continuously valid, out_ready=1. Required: grant order 0,1,2,3,0. With rr=2 and only warps 0 and 3 eligible → grant 3.
- Backpressure: out_ready=0 for 5 cycles with out_valid=1. Required: out_* stable, all ibuf_ready=0, perf_stalls unchanged.
- Corner cases:
  - rd=x0 with wb=1: no reservation is made.
  - Same-cycle reserve and release of x5 on warp2: bit stays 1.
  - wb for an unreserved v7: err_spurious_wb=1 and stays set until reset.

Source files
------------

// File: rtl/vx_issue_scoreboard_pkg.sv
// Shared widths and the issue record handed from the scoreboard to operand collection.
package vx_issue_scoreboard_pkg;

    localparam int PER_ISSUE_WARPS = 4;
    localparam int WW              = (PER_ISSUE_WARPS > 1) ? $clog2(PER_ISSUE_WARPS) : 1;
    localparam int NR_BITS         = 6;
    localparam int NV_BITS         = 5;
    localparam int PAYLOAD_W       = 128;
    localparam int NUM_SREGS       = 1 << NR_BITS;
    localparam int NUM_VREGS       = 1 << NV_BITS;

    typedef struct packed {
        logic [PAYLOAD_W-1:0] payload;
        logic                 is_vec;
        logic [NR_BITS-1:0]   rd;
        logic [NR_BITS-1:0]   rs1;
        logic [NR_BITS-1:0]   rs2;
        logic [NR_BITS-1:0]   rs3;
        logic [NV_BITS-1:0]   vd;
        logic [NV_BITS-1:0]   vs1;
        logic [NV_BITS-1:0]   vs2;
    } issue_rec_t;

    // Next warp id, wrapping at the warp count (which need not be a power of two).
    function automatic logic [WW-1:0] wid_inc(input logic [WW-1:0] wid);
        return (wid == WW'(PER_ISSUE_WARPS - 1)) ? '0 : wid + 1'b1;
    endfunction

endpackage

// File: rtl/vx_rr_arbiter.sv
// Round-robin pick: first requester at or after ptr, wrapping; one-hot and encoded grant.
module vx_rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               grant_any
);

    logic [IDX_W-1:0] cand;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        cand      = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = IDX_W'((int'(ptr) + i) % NUM_REQ);
            if (!grant_any && req[cand]) begin
                grant_any = 1'b1;
                grant_idx = cand;
            end
        end
        if (grant_any) grant[grant_idx] = 1'b1;
    end

endmodule

// File: rtl/vx_issue_scoreboard.sv
// Per-warp scalar/vector register scoreboard: holds back hazarded buffer heads and
// round-robin issues one clean instruction per cycle into a registered output slot.
module vx_issue_scoreboard
    import vx_issue_scoreboard_pkg::*;
#(
    parameter int PERF_W = 44
) (
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic [PER_ISSUE_WARPS-1:0]                ibuf_valid,
    output logic [PER_ISSUE_WARPS-1:0]                ibuf_ready,
    input  logic [PER_ISSUE_WARPS-1:0][PAYLOAD_W-1:0] ibuf_payload,
    input  logic [PER_ISSUE_WARPS-1:0]                ibuf_wb,
    input  logic [PER_ISSUE_WARPS-1:0]                ibuf_is_vec,
    input  logic [PER_ISSUE_WARPS-1:0][NR_BITS-1:0]   ibuf_rd,
    input  logic [PER_ISSUE_WARPS-1:0][NR_BITS-1:0]   ibuf_rs1,
    input  logic [PER_ISSUE_WARPS-1:0][NR_BITS-1:0]   ibuf_rs2,
    input  logic [PER_ISSUE_WARPS-1:0][NR_BITS-1:0]   ibuf_rs3,
    input  logic [PER_ISSUE_WARPS-1:0][NV_BITS-1:0]   ibuf_vd,
    input  logic [PER_ISSUE_WARPS-1:0][NV_BITS-1:0]   ibuf_vs1,
    input  logic [PER_ISSUE_WARPS-1:0][NV_BITS-1:0]   ibuf_vs2,
    output logic                                      out_valid,
    input  logic                                      out_ready,
    output logic [WW-1:0]                             out_wid,
    output logic [PAYLOAD_W-1:0]                      out_payload,
    output logic                                      out_is_vec,
    output logic [NR_BITS-1:0]                        out_rd,
    output logic [NR_BITS-1:0]                        out_rs1,
    output logic [NR_BITS-1:0]                        out_rs2,
    output logic [NR_BITS-1:0]                        out_rs3,
    output logic [NV_BITS-1:0]                        out_vd,
    output logic [NV_BITS-1:0]                        out_vs1,
    output logic [NV_BITS-1:0]                        out_vs2,
    input  logic                                      wb_valid,
    input  logic [WW-1:0]                             wb_wid,
    input  logic                                      wb_is_vec,
    input  logic [NR_BITS-1:0]                        wb_rd,
    input  logic [NV_BITS-1:0]                        wb_vd,
    output logic [PERF_W-1:0]                         perf_stalls,
    output logic                                      err_spurious_wb
);

    localparam int W = PER_ISSUE_WARPS;

    logic [W-1:0][NUM_SREGS-1:0] sbusy, sbusy_set, sbusy_clr;
    logic [W-1:0][NUM_VREGS-1:0] vbusy, vbusy_set, vbusy_clr;
    logic [W-1:0]                hazard, eligible, gnt_onehot;
    logic [WW-1:0]               rr, gnt_idx;
    logic                        gnt_any, can_load, issue;
    logic                        wb_live, wb_bit;
    issue_rec_t                  sel_rec, out_rec;

    // sbusy[.][0] is never set, so x0 sources and destinations never hazard.
    for (genvar w = 0; w < W; w++) begin : g_haz
        assign hazard[w] = ibuf_is_vec[w]
            ? (vbusy[w][ibuf_vs1[w]] | vbusy[w][ibuf_vs2[w]]
               | (ibuf_wb[w] & vbusy[w][ibuf_vd[w]]) | sbusy[w][ibuf_rs1[w]])
            : (sbusy[w][ibuf_rs1[w]] | sbusy[w][ibuf_rs2[w]] | sbusy[w][ibuf_rs3[w]]
               | (ibuf_wb[w] & sbusy[w][ibuf_rd[w]]));
    end

    assign eligible = ibuf_valid & ~hazard;
    assign can_load = ~out_valid | out_ready;

    vx_rr_arbiter #(
        .NUM_REQ (W),
        .IDX_W   (WW)
    ) u_arb (
        .req       (eligible),
        .ptr       (rr),
        .grant     (gnt_onehot),
        .grant_idx (gnt_idx),
        .grant_any (gnt_any)
    );

    assign issue      = can_load & gnt_any;
    assign ibuf_ready = gnt_onehot & {W{issue}};

    assign wb_live = wb_valid & (wb_is_vec | (wb_rd != '0));
    assign wb_bit  = wb_is_vec ? vbusy[wb_wid][wb_vd] : sbusy[wb_wid][wb_rd];

    always_comb begin
        sbusy_set = '0;
        sbusy_clr = '0;
        vbusy_set = '0;
        vbusy_clr = '0;
        if (issue && ibuf_wb[gnt_idx]) begin
            if (ibuf_is_vec[gnt_idx])          vbusy_set[gnt_idx][ibuf_vd[gnt_idx]] = 1'b1;
            else if (ibuf_rd[gnt_idx] != '0)   sbusy_set[gnt_idx][ibuf_rd[gnt_idx]] = 1'b1;
        end
        if (wb_live) begin
            if (wb_is_vec) vbusy_clr[wb_wid][wb_vd] = 1'b1;
            else           sbusy_clr[wb_wid][wb_rd] = 1'b1;
        end
    end

    assign sel_rec = '{
        payload: ibuf_payload[gnt_idx],
        is_vec:  ibuf_is_vec[gnt_idx],
        rd:      ibuf_rd[gnt_idx],
        rs1:     ibuf_rs1[gnt_idx],
        rs2:     ibuf_rs2[gnt_idx],
        rs3:     ibuf_rs3[gnt_idx],
        vd:      ibuf_vd[gnt_idx],
        vs1:     ibuf_vs1[gnt_idx],
        vs2:     ibuf_vs2[gnt_idx]
    };

    // Release applied before reserve so a same-cycle reserve of the same bit wins.
    always_ff @(posedge clk) begin
        if (reset) begin
            sbusy           <= '0;
            vbusy           <= '0;
            rr              <= '0;
            perf_stalls     <= '0;
            err_spurious_wb <= 1'b0;
        end else begin
            sbusy <= (sbusy & ~sbusy_clr) | sbusy_set;
            vbusy <= (vbusy & ~vbusy_clr) | vbusy_set;
            if (issue) rr <= wid_inc(gnt_idx);
            if ((|ibuf_valid) && can_load && !issue && (perf_stalls != '1))
                perf_stalls <= perf_stalls + 1'b1;
            if (wb_live && !wb_bit) err_spurious_wb <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_wid   <= '0;
            out_rec   <= '0;
        end else if (issue) begin
            out_valid <= 1'b1;
            out_wid   <= gnt_idx;
            out_rec   <= sel_rec;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    assign out_payload = out_rec.payload;
    assign out_is_vec  = out_rec.is_vec;
    assign out_rd      = out_rec.rd;
    assign out_rs1     = out_rec.rs1;
    assign out_rs2     = out_rec.rs2;
    assign out_rs3     = out_rec.rs3;
    assign out_vd      = out_rec.vd;
    assign out_vs1     = out_rec.vs1;
    assign out_vs2     = out_rec.vs2;

endmodule

// File: tb/tb_vx_issue_scoreboard.sv
// Bench for vx_issue_scoreboard: directed scenarios with literal expectations, then
// random traffic checked every cycle against a register-set model of the scoreboard.
module tb_vx_issue_scoreboard;
    import vx_issue_scoreboard_pkg::*;

    localparam int    W        = PER_ISSUE_WARPS;
    localparam int    PERF_W   = 44;
    localparam longint PERF_MAX = (longint'(1) << PERF_W) - 1;

    logic                        clk = 1'b0;
    logic                        reset;
    logic [W-1:0]                ibuf_valid, ibuf_ready, ibuf_wb, ibuf_is_vec;
    logic [W-1:0][PAYLOAD_W-1:0] ibuf_payload;
    logic [W-1:0][NR_BITS-1:0]   ibuf_rd, ibuf_rs1, ibuf_rs2, ibuf_rs3;
    logic [W-1:0][NV_BITS-1:0]   ibuf_vd, ibuf_vs1, ibuf_vs2;
    logic                        out_valid, out_ready, out_is_vec;
    logic [WW-1:0]               out_wid, wb_wid;
    logic [PAYLOAD_W-1:0]        out_payload;
    logic [NR_BITS-1:0]          out_rd, out_rs1, out_rs2, out_rs3, wb_rd;
    logic [NV_BITS-1:0]          out_vd, out_vs1, out_vs2, wb_vd;
    logic                        wb_valid, wb_is_vec, err_spurious_wb;
    logic [PERF_W-1:0]           perf_stalls;

    always #5 clk = ~clk;

    vx_issue_scoreboard #(.PERF_W(PERF_W)) dut (
        .clk(clk), .reset(reset),
        .ibuf_valid(ibuf_valid), .ibuf_ready(ibuf_ready), .ibuf_payload(ibuf_payload),
        .ibuf_wb(ibuf_wb), .ibuf_is_vec(ibuf_is_vec),
        .ibuf_rd(ibuf_rd), .ibuf_rs1(ibuf_rs1), .ibuf_rs2(ibuf_rs2), .ibuf_rs3(ibuf_rs3),
        .ibuf_vd(ibuf_vd), .ibuf_vs1(ibuf_vs1), .ibuf_vs2(ibuf_vs2),
        .out_valid(out_valid), .out_ready(out_ready), .out_wid(out_wid),
        .out_payload(out_payload), .out_is_vec(out_is_vec),
        .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rs3(out_rs3),
        .out_vd(out_vd), .out_vs1(out_vs1), .out_vs2(out_vs2),
        .wb_valid(wb_valid), .wb_wid(wb_wid), .wb_is_vec(wb_is_vec),
        .wb_rd(wb_rd), .wb_vd(wb_vd),
        .perf_stalls(perf_stalls), .err_spurious_wb(err_spurious_wb)
    );

    // Reference: which registers each warp has in flight, plus the issue slot contents.
    bit         m_sb [W][NUM_SREGS];
    bit         m_vb [W][NUM_VREGS];
    int         m_rr, m_wid, m_g, m_last_g;
    bit         m_ov, m_err, m_known;
    longint     m_perf;
    issue_rec_t m_rec;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    task automatic chk(input string name, input logic [PAYLOAD_W-1:0] act,
                       input logic [PAYLOAD_W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
        end
    endtask

    function automatic bit s_busy(input int w, input int r);
        return (r != 0) && m_sb[w][r];
    endfunction

    function automatic bit m_hazard(input int w);
        if (ibuf_is_vec[w])
            return m_vb[w][ibuf_vs1[w]] || m_vb[w][ibuf_vs2[w]]
                || (ibuf_wb[w] && m_vb[w][ibuf_vd[w]]) || s_busy(w, int'(ibuf_rs1[w]));
        return s_busy(w, int'(ibuf_rs1[w])) || s_busy(w, int'(ibuf_rs2[w]))
            || s_busy(w, int'(ibuf_rs3[w])) || (ibuf_wb[w] && s_busy(w, int'(ibuf_rd[w])));
    endfunction

    task automatic m_eval();
        m_g = -1;
        if (!m_ov || out_ready)
            for (int i = 0; i < W; i++) begin
                int w = (m_rr + i) % W;
                if (m_g < 0 && ibuf_valid[w] && !m_hazard(w)) m_g = w;
            end
    endtask

    task automatic compare();
        logic [W-1:0] exp_rdy = '0;
        if (m_g >= 0) exp_rdy[m_g] = 1'b1;
        chk("ibuf_ready", ibuf_ready, exp_rdy);
        chk("out_valid", out_valid, m_ov);
        chk("out_wid", out_wid, m_wid);
        chk("out_payload", out_payload, m_rec.payload);
        chk("out_is_vec", out_is_vec, m_rec.is_vec);
        chk("out_scalar_idx", {out_rd, out_rs1, out_rs2, out_rs3},
            {m_rec.rd, m_rec.rs1, m_rec.rs2, m_rec.rs3});
        chk("out_vector_idx", {out_vd, out_vs1, out_vs2}, {m_rec.vd, m_rec.vs1, m_rec.vs2});
        chk("perf_stalls", perf_stalls, m_perf);
        chk("err_spurious_wb", err_spurious_wb, m_err);
    endtask

    task automatic m_commit();
        if (reset) begin
            m_sb = '{default: '{default: 1'b0}};
            m_vb = '{default: '{default: 1'b0}};
            m_rr = 0; m_wid = 0; m_ov = 0; m_err = 0; m_perf = 0; m_rec = '0;
            m_last_g = -1; m_known = 1;
            return;
        end
        if (wb_valid) begin
            int w = int'(wb_wid);
            if (wb_is_vec) begin
                if (!m_vb[w][wb_vd]) m_err = 1;
                m_vb[w][wb_vd] = 0;
            end else if (wb_rd != 0) begin
                if (!m_sb[w][wb_rd]) m_err = 1;
                m_sb[w][wb_rd] = 0;
            end
        end
        if (m_g < 0 && (!m_ov || out_ready) && (|ibuf_valid) && m_perf < PERF_MAX) m_perf++;
        m_last_g = m_g;
        if (m_g >= 0) begin
            if (ibuf_wb[m_g]) begin
                if (ibuf_is_vec[m_g])      m_vb[m_g][ibuf_vd[m_g]] = 1;
                else if (ibuf_rd[m_g] != 0) m_sb[m_g][ibuf_rd[m_g]] = 1;
            end
            m_rec = '{payload: ibuf_payload[m_g], is_vec: ibuf_is_vec[m_g],
                      rd: ibuf_rd[m_g], rs1: ibuf_rs1[m_g], rs2: ibuf_rs2[m_g],
                      rs3: ibuf_rs3[m_g], vd: ibuf_vd[m_g], vs1: ibuf_vs1[m_g],
                      vs2: ibuf_vs2[m_g]};
            m_wid = m_g;
            m_ov  = 1;
            m_rr  = (m_g + 1) % W;
        end else if (out_ready) begin
            m_ov = 0;
        end
    endtask

    // One clock: check against the model mid-cycle, advance the model, return at negedge.
    task automatic tick();
        #1;
        m_eval();
        if (m_known) compare();
        m_commit();
        @(negedge clk);
        cyc++;
    endtask

    task automatic set_s(input int w, input int rd, input int rs1, input int rs2,
                         input int rs3, input bit wb);
        ibuf_valid[w] = 1'b1; ibuf_is_vec[w] = 1'b0; ibuf_wb[w] = wb;
        ibuf_rd[w]  = NR_BITS'(rd);  ibuf_rs1[w] = NR_BITS'(rs1);
        ibuf_rs2[w] = NR_BITS'(rs2); ibuf_rs3[w] = NR_BITS'(rs3);
        ibuf_vd[w]  = NV_BITS'($urandom); ibuf_vs1[w] = NV_BITS'($urandom);
        ibuf_vs2[w] = NV_BITS'($urandom);
        ibuf_payload[w] = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic set_v(input int w, input int vd, input int vs1, input int vs2,
                         input int rs1, input bit wb);
        ibuf_valid[w] = 1'b1; ibuf_is_vec[w] = 1'b1; ibuf_wb[w] = wb;
        ibuf_vd[w]  = NV_BITS'(vd); ibuf_vs1[w] = NV_BITS'(vs1); ibuf_vs2[w] = NV_BITS'(vs2);
        ibuf_rs1[w] = NR_BITS'(rs1);
        ibuf_rd[w]  = NR_BITS'($urandom); ibuf_rs2[w] = NR_BITS'($urandom);
        ibuf_rs3[w] = NR_BITS'($urandom);
        ibuf_payload[w] = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic wb_s(input int w, input int rd);
        wb_valid = 1'b1; wb_wid = WW'(w); wb_is_vec = 1'b0; wb_rd = NR_BITS'(rd);
    endtask

    task automatic wb_v(input int w, input int vd);
        wb_valid = 1'b1; wb_wid = WW'(w); wb_is_vec = 1'b1; wb_vd = NV_BITS'(vd);
    endtask

    task automatic do_reset();
        reset = 1'b1; ibuf_valid = '0; wb_valid = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    task automatic rand_head(input int w);
        if ($urandom_range(0, 2) == 0)
            set_v(w, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                  $urandom_range(0, 7), $urandom_range(0, 9) < 7);
        else
            set_s(w, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
                  $urandom_range(0, 7), $urandom_range(0, 9) < 7);
    endtask

    task automatic rand_wb();
        int cand[$];
        wb_valid = 1'b0;
        if ($urandom_range(0, 99) == 0) begin
            if ($urandom_range(0, 1) == 0) wb_s($urandom_range(0, W - 1), $urandom_range(0, 7));
            else                           wb_v($urandom_range(0, W - 1), $urandom_range(0, 3));
            return;
        end
        if ($urandom_range(0, 2) != 0) return;
        for (int w = 0; w < W; w++) begin
            for (int r = 1; r < NUM_SREGS; r++) if (m_sb[w][r]) cand.push_back(w * 256 + r);
            for (int r = 0; r < NUM_VREGS; r++) if (m_vb[w][r]) cand.push_back(w * 256 + 128 + r);
        end
        if (cand.size() == 0) return;
        begin
            int c = cand[$urandom_range(0, cand.size() - 1)];
            if ((c % 256) >= 128) wb_v(c / 256, (c % 256) - 128);
            else                  wb_s(c / 256, c % 256);
        end
    endtask

    initial begin
        reset = 1'b1; out_ready = 1'b1;
        ibuf_valid = '0; ibuf_wb = '0; ibuf_is_vec = '0; ibuf_payload = '0;
        ibuf_rd = '0; ibuf_rs1 = '0; ibuf_rs2 = '0; ibuf_rs3 = '0;
        ibuf_vd = '0; ibuf_vs1 = '0; ibuf_vs2 = '0;
        wb_valid = 1'b0; wb_wid = '0; wb_is_vec = 1'b0; wb_rd = '0; wb_vd = '0;
        m_known = 0; m_last_g = -1;
        @(negedge clk);
        tick();
        do_reset();
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_perf", perf_stalls, 0);
        chk("rst_err", err_spurious_wb, 1'b0);

        // Independent scalar writes issue back to back; then a RAW on x5 stalls.
        set_s(0, 5, 1, 2, 0, 1); #1 chk("indep_grant_a", ibuf_ready, 4'b0001); tick();
        set_s(0, 6, 3, 4, 0, 1); #1 chk("indep_grant_b", ibuf_ready, 4'b0001);
        chk("indep_out_a", {out_valid, out_rd}, {1'b1, 6'd5}); tick();
        set_s(0, 7, 5, 1, 0, 1); #1 chk("raw_block", ibuf_ready, 4'b0000);
        chk("indep_out_b", out_rd, 6'd6);
        repeat (3) tick();
        chk("raw_perf3", perf_stalls, 3);
        wb_s(0, 5); #1 chk("raw_no_bypass", ibuf_ready, 4'b0000); tick();
        wb_valid = 1'b0; #1 chk("raw_release_grant", ibuf_ready, 4'b0001); tick();
        chk("raw_issue_latency", {out_valid, out_rd}, {1'b1, 6'd7});
        chk("raw_perf4", perf_stalls, 4);
        set_s(0, 8, 6, 0, 0, 1); #1 chk("x6_still_busy", ibuf_ready, 4'b0000); tick();
        wb_s(0, 6); tick();
        wb_s(0, 7); #1 chk("x6_release_grant", ibuf_ready, 4'b0001); tick();
        ibuf_valid = '0; wb_s(0, 8); tick();
        wb_valid = 1'b0;

        // Vector WAW on v3 combined with a busy scalar operand x9.
        set_s(1, 9, 0, 0, 0, 1); #1 chk("vec_reserve_x9", ibuf_ready, 4'b0010); tick();
        set_v(1, 3, 1, 2, 0, 1); #1 chk("vec_reserve_v3", ibuf_ready, 4'b0010); tick();
        set_v(1, 3, 4, 5, 9, 1); #1 chk("vec_waw_block", ibuf_ready, 4'b0000); tick(); tick();
        wb_v(1, 3); tick();
        wb_valid = 1'b0; #1 chk("vec_x9_block", ibuf_ready, 4'b0000); tick();
        wb_s(1, 9); tick();
        wb_valid = 1'b0; #1 chk("vec_release_grant", ibuf_ready, 4'b0010); tick();
        ibuf_valid = '0; tick();

        // Round robin across all warps, then rr=2 with only warps 0 and 3 requesting.
        do_reset();
        for (int w = 0; w < W; w++) set_s(w, 0, w + 1, 0, 0, 0);
        for (int k = 0; k < 6; k++) begin
            logic [W-1:0] exp_oh;
            exp_oh = '0;
            exp_oh[k % W] = 1'b1;
            #1 chk("rr_order", ibuf_ready, exp_oh);
            tick();
        end
        ibuf_valid = 4'b1001; #1 chk("rr_skip_to_3", ibuf_ready, 4'b1000); tick();

        // Backpressure: slot full and not accepted.
        ibuf_valid = 4'b1111; out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #1 chk("bp_no_pop", ibuf_ready, 4'b0000);
            chk("bp_hold", {out_valid, out_wid}, {1'b1, 2'd3});
            chk("bp_perf", perf_stalls, 0);
            tick();
        end
        out_ready = 1'b1; #1 chk("bp_resume", ibuf_ready, 4'b0001); tick();
        ibuf_valid = '0; tick();

        // x0 destination, spurious vector writeback, same-cycle reserve/release.
        set_s(0, 0, 0, 0, 0, 1); tick();
        set_s(0, 0, 0, 0, 0, 1); #1 chk("x0_no_reserve", ibuf_ready, 4'b0001); tick();
        ibuf_valid = '0;
        chk("err_clear", err_spurious_wb, 1'b0);
        wb_v(2, 7); tick();
        wb_valid = 1'b0;
        chk("err_set", err_spurious_wb, 1'b1);
        tick(); tick();
        chk("err_sticky", err_spurious_wb, 1'b1);
        set_s(2, 5, 0, 0, 0, 1); wb_s(2, 5); #1 chk("same_cyc_grant", ibuf_ready, 4'b0100); tick();
        wb_valid = 1'b0;
        set_s(2, 8, 5, 0, 0, 1); #1 chk("reserve_wins", ibuf_ready, 4'b0000); tick();
        ibuf_valid = '0; wb_s(2, 5); tick();
        wb_valid = 1'b0;
        do_reset();
        chk("err_reset", err_spurious_wb, 1'b0);

        // Random traffic, including one reset mid-stream.
        for (int n = 0; n < 800; n++) begin
            for (int w = 0; w < W; w++)
                if (m_last_g == w || !ibuf_valid[w]) begin
                    if ($urandom_range(0, 4) != 0) rand_head(w);
                    else ibuf_valid[w] = 1'b0;
                end
            out_ready = ($urandom_range(0, 3) != 0);
            rand_wb();
            reset = (n == 400);
            tick();
        end
        reset = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
